// File: rtl/lcd_pkg.sv
// Shared LCD controller constants: FSM encodings, RS values,
// default bus timing and the busy-flag bit position.
package lcd_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_EHIGH   = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  localparam logic RS_INSTR = 1'b0;
  localparam logic RS_DATA  = 1'b1;

  localparam int T_AS_DEF  = 3;
  localparam int T_PW_DEF  = 12;
  localparam int T_AH_DEF  = 2;
  localparam int T_REC_DEF = 10;

  localparam int BF_BIT = 7;

  function automatic int max4(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/read_lcd_block_timer.sv
// lcd_phase_timer: loadable down-counter, done when it reaches zero.
// A load of N-1 makes the phase last N cycles.
module lcd_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset_n)
      count_q <= '0;
    else if (load_i)
      count_q <= load_val_i;
    else if (count_q != '0)
      count_q <= count_q - 1'b1;
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/read_lcd_block.sv
// HD44780 read cycle engine: RW=1, timed E pulse, sample at E end.
// Optional `BUSY_POLL_EN repeats RS=0 reads until the busy flag clears.
import lcd_pkg::*;

module read_lcd_block #(
  parameter int T_AS  = T_AS_DEF,
  parameter int T_PW  = T_PW_DEF,
  parameter int T_AH  = T_AH_DEF,
  parameter int T_REC = T_REC_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rd_req,
  input  logic       rd_rs,
  input  logic [7:0] data_lcd_rd,
  output logic       RW_rd_lcd,
  output logic       RS_rd_lcd,
  output logic       E_rd_lcd,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       lcd_busy_flag,
  output logic       busy_o
);

  localparam int CW = $clog2(max4(T_AS, T_PW, T_AH, T_REC)) + 1;

  logic [2:0]    state_q, state_d;
  logic          rw_q, rw_d, rs_q, rs_d, e_q, e_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d, bf_q, bf_d;
  logic          busy_q, busy_d;
  logic          ld;
  logic [CW-1:0] ld_val;
  logic          done;
`ifdef BUSY_POLL_EN
  logic          poll_q, poll_d;
`endif

  lcd_phase_timer #(.W(CW)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (ld),
    .load_val_i (ld_val),
    .done_o     (done)
  );

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    rs_d    = rs_q;
    e_d     = e_q;
    data_d  = data_q;
    valid_d = 1'b0;
    bf_d    = bf_q;
    busy_d  = busy_q;
    ld      = 1'b0;
    ld_val  = '0;
`ifdef BUSY_POLL_EN
    poll_d  = poll_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          state_d = ST_SETUP;
          rw_d    = 1'b1;
          rs_d    = rd_rs;
          busy_d  = 1'b1;
          ld      = 1'b1;
          ld_val  = CW'(T_AS - 1);
        end
      end
      ST_SETUP: begin
        if (done) begin
          state_d = ST_EHIGH;
          e_d     = 1'b1;
          ld      = 1'b1;
          ld_val  = CW'(T_PW - 1);
        end
      end
      ST_EHIGH: begin
        if (done) begin
          state_d = ST_HOLD;
          e_d     = 1'b0;
          data_d  = data_lcd_rd;
          ld      = 1'b1;
          ld_val  = CW'(T_AH - 1);
          if (rs_q == RS_INSTR)
            bf_d = data_lcd_rd[BF_BIT];
`ifdef BUSY_POLL_EN
          poll_d  = (rs_q == RS_INSTR) && data_lcd_rd[BF_BIT];
          valid_d = !poll_d;
`else
          valid_d = 1'b1;
`endif
        end
      end
      ST_HOLD: begin
        if (done) begin
          state_d = ST_RECOVER;
          rw_d    = 1'b0;
          rs_d    = 1'b0;
          ld      = 1'b1;
          ld_val  = CW'(T_REC - 1);
        end
      end
      ST_RECOVER: begin
        if (done) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
`ifdef BUSY_POLL_EN
          // Busy flag still set: re-issue the RS=0 read directly
          if (poll_q) begin
            state_d = ST_SETUP;
            busy_d  = 1'b1;
            rw_d    = 1'b1;
            rs_d    = RS_INSTR;
            ld      = 1'b1;
            ld_val  = CW'(T_AS - 1);
          end
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        rw_d    = 1'b0;
        rs_d    = 1'b0;
        e_d     = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rw_q    <= 1'b0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      bf_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef BUSY_POLL_EN
      poll_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      bf_q    <= bf_d;
      busy_q  <= busy_d;
`ifdef BUSY_POLL_EN
      poll_q  <= poll_d;
`endif
    end
  end

  assign RW_rd_lcd     = rw_q;
  assign RS_rd_lcd     = rs_q;
  assign E_rd_lcd      = e_q;
  assign rd_data       = data_q;
  assign rd_valid      = valid_q;
  assign lcd_busy_flag = bf_q;
  assign busy_o        = busy_q;

endmodule
